// File: rtl/axil_pkg.sv
// Shared types and width constants for the AXI4-Lite peripheral crossbar.
package axil_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    // Response codes returned upstream on BRESP/RRESP.
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // Request/response channel FSM, shared by the write and read paths.
    typedef enum logic [1:0] {
        CH_IDLE,
        CH_FWD,
        CH_RESP,
        CH_OUT
    } chan_state_t;

endpackage

// File: rtl/axil_xbar_chan.sv
// Generic one-outstanding request/response channel with timeout.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid, req_mapped    upstream request present / decodes to a slave
//   accept_c, idle           request taken this cycle / channel ready for a request
//   fwd_ready, fwd_pend      per-subchannel downstream ready / valid still pending
//   resp_valid, resp_ready   downstream response handshake
//   out_valid, out_resp      upstream response and its code
//   out_ready                upstream response accepted
module axil_xbar_chan
    import axil_pkg::*;
#(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_mapped,
    output logic            accept_c,
    output logic            idle,
    input  logic [NREQ-1:0] fwd_ready,
    output logic [NREQ-1:0] fwd_pend,
    input  logic            resp_valid,
    output logic            resp_ready,
    output logic            out_valid,
    output resp_t           out_resp,
    input  logic            out_ready
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
    localparam bit          TMO_EN  = (TIMEOUT_CYC != 0);

    chan_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0] pend_q, pend_d;
    logic            rdy_q, rdy_d;
    logic            ovalid_q, ovalid_d;
    resp_t           oresp_q, oresp_d;
    logic            idle_q, idle_d;
    logic            tmo_c;

    // idle_q implies state_q == CH_IDLE; it is low for one cycle after reset.
    assign accept_c = idle_q && req_valid;

    // Counter reaches TIMEOUT_CYC on the same edge the channel gives up.
    assign tmo_c = TMO_EN && (CNT_W'(cnt_q + CNT_W'(1)) == CNT_MAX);

    // Next-state and output-register logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        rdy_d    = rdy_q;
        ovalid_d = ovalid_q;
        oresp_d  = oresp_q;

        case (state_q)
            CH_IDLE: begin
                if (accept_c) begin
                    if (req_mapped) begin
                        state_d = CH_FWD;
                        cnt_d   = '0;
                        pend_d  = '1;
                    end else begin
                        state_d  = CH_OUT;
                        ovalid_d = 1'b1;
                        oresp_d  = DECERR;
                    end
                end
            end
            CH_FWD: begin
                cnt_d  = CNT_W'(cnt_q + CNT_W'(1));
                pend_d = pend_q & ~fwd_ready;
                if (tmo_c) begin
                    state_d  = CH_OUT;
                    pend_d   = '0;
                    ovalid_d = 1'b1;
                    oresp_d  = SLVERR;
                end else if (pend_d == '0) begin
                    state_d = CH_RESP;
                    rdy_d   = 1'b1;
                end
            end
            CH_RESP: begin
                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                // A response arriving on the timeout cycle has been consumed, so it wins.
                if (resp_valid) begin
                    state_d  = CH_OUT;
                    rdy_d    = 1'b0;
                    ovalid_d = 1'b1;
                    oresp_d  = OKAY;
                end else if (tmo_c) begin
                    state_d  = CH_OUT;
                    rdy_d    = 1'b0;
                    ovalid_d = 1'b1;
                    oresp_d  = SLVERR;
                end
            end
            CH_OUT: begin
                if (out_ready) begin
                    state_d  = CH_IDLE;
                    ovalid_d = 1'b0;
                end
            end
            default: state_d = CH_IDLE;
        endcase

        idle_d = (state_d == CH_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CH_IDLE;
            cnt_q    <= '0;
            pend_q   <= '0;
            rdy_q    <= 1'b0;
            ovalid_q <= 1'b0;
            oresp_q  <= OKAY;
            idle_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            rdy_q    <= rdy_d;
            ovalid_q <= ovalid_d;
            oresp_q  <= oresp_d;
            idle_q   <= idle_d;
        end
    end

    assign idle       = idle_q;
    assign fwd_pend   = pend_q;
    assign resp_ready = rdy_q;
    assign out_valid  = ovalid_q;
    assign out_resp   = oresp_q;

endmodule

// File: rtl/axil_periph_xbar.sv
// 1-to-N AXI4-Lite peripheral interconnect with DECERR for unmapped windows
// and SLVERR on per-transaction timeout.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*                  upstream write address/data/response
//   s_ar*/s_r*                       upstream read address/data
//   m_awaddr/m_wdata/m_wstrb         shared registered write payload
//   m_aw*/m_w*/m_b* handshakes       per-slave one-hot write handshakes
//   m_araddr, m_ar*/m_r* handshakes  shared read address, per-slave handshakes
//   m_rdata                          packed slave read data, slave i at [32i+31:32i]
module axil_periph_xbar
    import axil_pkg::*;
#(
    parameter int unsigned NUM_SLAVES  = 5,
    parameter int unsigned SEL_LSB     = 12,
    parameter int unsigned SEL_W       = 3,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [AXI_ADDR_W-1:0]            s_awaddr,
    input  logic                             s_awvalid,
    output logic                             s_awready,
    input  logic [AXI_DATA_W-1:0]            s_wdata,
    input  logic [AXI_STRB_W-1:0]            s_wstrb,
    input  logic                             s_wvalid,
    output logic                             s_wready,
    output logic [1:0]                       s_bresp,
    output logic                             s_bvalid,
    input  logic                             s_bready,
    input  logic [AXI_ADDR_W-1:0]            s_araddr,
    input  logic                             s_arvalid,
    output logic                             s_arready,
    output logic [AXI_DATA_W-1:0]            s_rdata,
    output logic [1:0]                       s_rresp,
    output logic                             s_rvalid,
    input  logic                             s_rready,
    output logic [AXI_ADDR_W-1:0]            m_awaddr,
    output logic [AXI_DATA_W-1:0]            m_wdata,
    output logic [AXI_STRB_W-1:0]            m_wstrb,
    output logic [NUM_SLAVES-1:0]            m_awvalid,
    input  logic [NUM_SLAVES-1:0]            m_awready,
    output logic [NUM_SLAVES-1:0]            m_wvalid,
    input  logic [NUM_SLAVES-1:0]            m_wready,
    input  logic [NUM_SLAVES-1:0]            m_bvalid,
    output logic [NUM_SLAVES-1:0]            m_bready,
    output logic [AXI_ADDR_W-1:0]            m_araddr,
    output logic [NUM_SLAVES-1:0]            m_arvalid,
    input  logic [NUM_SLAVES-1:0]            m_arready,
    input  logic [AXI_DATA_W*NUM_SLAVES-1:0] m_rdata,
    input  logic [NUM_SLAVES-1:0]            m_rvalid,
    output logic [NUM_SLAVES-1:0]            m_rready
);

    logic [SEL_W-1:0]      aw_idx_c, ar_idx_c;
    logic                  aw_map_c, ar_map_c;
    logic [NUM_SLAVES-1:0] aw_sel_c, ar_sel_c;
    logic [NUM_SLAVES-1:0] wr_sel_q, rd_sel_q;
    logic                  wr_accept_c, rd_accept_c;
    logic                  wr_idle, rd_idle;
    logic [1:0]            wr_pend;
    logic [0:0]            rd_pend;
    logic                  wr_resp_rdy, rd_resp_rdy;
    resp_t                 wr_resp, rd_resp;
    logic                  rd_take_c;
    logic [AXI_DATA_W-1:0] rd_slice_c;
    logic [AXI_DATA_W-1:0] rdata_q;

    // Slave index decode; an out-of-range index yields an all-zero select.
    assign aw_idx_c = s_awaddr[SEL_LSB +: SEL_W];
    assign ar_idx_c = s_araddr[SEL_LSB +: SEL_W];
    assign aw_map_c = (32'(aw_idx_c) < NUM_SLAVES);
    assign ar_map_c = (32'(ar_idx_c) < NUM_SLAVES);
    assign aw_sel_c = aw_map_c ? (NUM_SLAVES'(1) << aw_idx_c) : '0;
    assign ar_sel_c = ar_map_c ? (NUM_SLAVES'(1) << ar_idx_c) : '0;

    axil_xbar_chan #(
        .NREQ        (2),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wr_chan (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (s_awvalid && s_wvalid),
        .req_mapped (aw_map_c),
        .accept_c   (wr_accept_c),
        .idle       (wr_idle),
        .fwd_ready  ({|(m_wready & wr_sel_q), |(m_awready & wr_sel_q)}),
        .fwd_pend   (wr_pend),
        .resp_valid (|(m_bvalid & wr_sel_q)),
        .resp_ready (wr_resp_rdy),
        .out_valid  (s_bvalid),
        .out_resp   (wr_resp),
        .out_ready  (s_bready)
    );

    axil_xbar_chan #(
        .NREQ        (1),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rd_chan (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (s_arvalid),
        .req_mapped (ar_map_c),
        .accept_c   (rd_accept_c),
        .idle       (rd_idle),
        .fwd_ready  (|(m_arready & rd_sel_q)),
        .fwd_pend   (rd_pend),
        .resp_valid (|(m_rvalid & rd_sel_q)),
        .resp_ready (rd_resp_rdy),
        .out_valid  (s_rvalid),
        .out_resp   (rd_resp),
        .out_ready  (s_rready)
    );

    // Read data mux from the selected slave.
    always_comb begin
        rd_slice_c = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (rd_sel_q[i]) rd_slice_c = m_rdata[i*AXI_DATA_W +: AXI_DATA_W];
        end
    end

    assign rd_take_c = rd_resp_rdy && |(m_rvalid & rd_sel_q);

    // Request payload and selected-slave registers; rdata cleared on accept so
    // DECERR and SLVERR responses carry zero data.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_awaddr <= '0;
            m_wdata  <= '0;
            m_wstrb  <= '0;
            wr_sel_q <= '0;
            m_araddr <= '0;
            rd_sel_q <= '0;
            rdata_q  <= '0;
        end else begin
            if (wr_accept_c) begin
                m_awaddr <= s_awaddr;
                m_wdata  <= s_wdata;
                m_wstrb  <= s_wstrb;
                wr_sel_q <= aw_sel_c;
            end
            if (rd_accept_c) begin
                m_araddr <= s_araddr;
                rd_sel_q <= ar_sel_c;
                rdata_q  <= '0;
            end else if (rd_take_c) begin
                rdata_q  <= rd_slice_c;
            end
        end
    end

    assign s_awready = wr_accept_c;
    assign s_wready  = wr_accept_c;
    assign s_arready = rd_idle;
    assign s_bresp   = wr_resp;
    assign s_rresp   = rd_resp;
    assign s_rdata   = rdata_q;

    // One-hot fan-out of the channel handshakes to the selected slave.
    assign m_awvalid = wr_sel_q & {NUM_SLAVES{wr_pend[0]}};
    assign m_wvalid  = wr_sel_q & {NUM_SLAVES{wr_pend[1]}};
    assign m_bready  = wr_sel_q & {NUM_SLAVES{wr_resp_rdy}};
    assign m_arvalid = rd_sel_q & {NUM_SLAVES{rd_pend[0]}};
    assign m_rready  = rd_sel_q & {NUM_SLAVES{rd_resp_rdy}};

endmodule
